// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit:
// instruction codes, status codes, register IDs and FSM states.
package pipe_hazard_unit_pkg;

    localparam logic [7:0] IMRMOVL = 8'h5;
    localparam logic [7:0] IJXX    = 8'h7;
    localparam logic [7:0] IRET    = 8'h9;
    localparam logic [7:0] IPOPL   = 8'hB;

    localparam logic [7:0] SAOK = 8'h1;
    localparam logic [7:0] SHLT = 8'h2;
    localparam logic [7:0] SADR = 8'h3;
    localparam logic [7:0] SINS = 8'h4;

    localparam logic [7:0] RNONE = 8'hF;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating performance counter with synchronous reset.
// Ports: clk, rst, inc_i (count this cycle), cnt_o (current count).
module pipe_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard/control unit: stage stall and bubble controls, data-memory wait FSM,
// sticky memory-timeout flag, and stall/bubble performance counters.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int ICODE_W     = 8,
    parameter int REG_W       = 8,
    parameter int STAT_W      = 8,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ICODE_W-1:0] D_icode_i,
    input  logic [ICODE_W-1:0] E_icode_i,
    input  logic [ICODE_W-1:0] M_icode_i,
    input  logic [REG_W-1:0]   d_srcA_i,
    input  logic [REG_W-1:0]   d_srcB_i,
    input  logic [REG_W-1:0]   E_dstM_i,
    input  logic               e_Cnd_i,
    input  logic [STAT_W-1:0]  m_stat_i,
    input  logic [STAT_W-1:0]  W_stat_i,
    input  logic               M_mem_req_i,
    input  logic               m_mem_ready_i,
    output logic               F_stall_o,
    output logic               D_stall_o,
    output logic               D_bubble_o,
    output logic               E_bubble_o,
    output logic               M_stall_o,
    output logic               M_bubble_o,
    output logic               W_stall_o,
    output logic               W_bubble_o,
    output logic               set_cc_o,
    output logic               halted_o,
    output logic               mem_fault_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;

    logic load_use, ret_haz, mispredict;
    logic w_exc, exc, mem_block;

    always_comb begin
        load_use   = ((E_icode_i == ICODE_W'(IMRMOVL)) ||
                      (E_icode_i == ICODE_W'(IPOPL))) &&
                     (E_dstM_i != REG_W'(RNONE)) &&
                     ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret_haz    = (D_icode_i == ICODE_W'(IRET)) ||
                     (E_icode_i == ICODE_W'(IRET)) ||
                     (M_icode_i == ICODE_W'(IRET));
        mispredict = (E_icode_i == ICODE_W'(IJXX)) && !e_Cnd_i;
        w_exc      = (W_stat_i != STAT_W'(SAOK));
        exc        = (m_stat_i != STAT_W'(SAOK)) || w_exc;
        // A memory access holds the pipe until the cycle ready arrives;
        // on that cycle normal hazard handling resumes.
        mem_block  = (((state_q == ST_RUN) && M_mem_req_i) ||
                      (state_q == ST_MEMWAIT)) && !m_mem_ready_i;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            ST_RUN: begin
                if (M_mem_req_i && !m_mem_ready_i) begin
                    state_d = ST_MEMWAIT;
                    wait_d  = '0;
                end
            end
            ST_MEMWAIT: begin
                if (m_mem_ready_i) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_HALTED;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        if (w_exc) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_stall_o  = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        W_bubble_o = 1'b0;
        set_cc_o   = 1'b0;
        halted_o   = 1'b0;
        if (rst) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else if (state_q == ST_HALTED) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
            halted_o  = 1'b1;
        end else if (mem_block) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            M_stall_o  = 1'b1;
            W_bubble_o = 1'b1;
        end else begin
            set_cc_o = 1'b1;
            if (load_use) begin
                F_stall_o  = 1'b1;
                D_stall_o  = 1'b1;
                E_bubble_o = 1'b1;
            end else if (mispredict) begin
                D_bubble_o = 1'b1;
                E_bubble_o = 1'b1;
            end else if (ret_haz) begin
                F_stall_o  = 1'b1;
                D_bubble_o = 1'b1;
            end
            if (exc) begin
                set_cc_o   = 1'b0;
                M_bubble_o = 1'b1;
                W_stall_o  = w_exc;
            end
        end
    end

    assign mem_fault_o = fault_q;

    logic stall_inc, bubble_inc;

    // Counters hold their value once the pipe is frozen.
    assign stall_inc  = F_stall_o && (state_q != ST_HALTED);
    assign bubble_inc = (E_bubble_o || D_bubble_o) && (state_q != ST_HALTED);

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );

endmodule
